// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard sequencer: forwarding encodings,
// FSM states and the shadow-scoreboard entry layout.
package pipe_pkg;

    localparam int REG_AW_DFLT = 3;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                   v;
        logic                   wr;
        logic [REG_AW_DFLT-1:0] dst;
        logic                   late;
        logic [REG_AW_DFLT-1:0] rs_a;
        logic [REG_AW_DFLT-1:0] rs_b;
        logic                   use_a;
        logic                   use_b;
        logic                   halt;
    } sb_entry_t;

    // An in-flight entry will write register r.
    function automatic logic sb_hit(sb_entry_t e, logic [REG_AW_DFLT-1:0] r);
        return e.v & e.wr & (e.dst == r);
    endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Decoder/EX-side signals into the hazard sequencer and the pipe controls out.
interface hazard_ctl_if #(parameter int REG_AW = pipe_pkg::REG_AW_DFLT);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs_a;
    logic [REG_AW-1:0] id_rs_b;
    logic              id_use_a;
    logic              id_use_b;
    logic              id_regwrite;
    logic [REG_AW-1:0] id_regdst;
    logic              id_late;
    logic              id_halt;
    logic              ex_branch_taken;
    logic              resume;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              halted;

    modport master (
        output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_regwrite,
               id_regdst, id_late, id_halt, ex_branch_taken, resume,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halted
    );

    modport slave (
        input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_regwrite,
               id_regdst, id_late, id_halt, ex_branch_taken, resume,
        output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halted
    );
endinterface

// File: rtl/hazard_sb_stage.sv
// One shadow-scoreboard entry: loads the incoming entry or an all-zero bubble.
module hazard_sb_stage
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    sb_entry_t ent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ent_q <= '0;
        else        ent_q <= load_i ? d_i : '0;
    end

    assign q_o = ent_q;

endmodule

// File: rtl/hazard_ctl.sv
// 5-stage pipeline sequencer: RAW stall/forward decisions from a shadow
// scoreboard, branch flush, and the halt drain / resume sequence.
module hazard_ctl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DFLT,
    parameter bit FWD_EN       = 1'b1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctl_if.slave  bus
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    sb_entry_t id_e, ex_q, mem_q, wb_q;

    logic [REG_AW-1:0] ra, rb;
    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, hit_wb_a, hit_wb_b;
    logic stall, flush, advance;

    assign ra = bus.id_rs_a;
    assign rb = bus.id_rs_b;

    always_comb begin
        id_e       = '0;
        id_e.v     = bus.id_valid;
        id_e.wr    = bus.id_regwrite;
        id_e.dst   = bus.id_regdst;
        id_e.late  = bus.id_late;
        id_e.rs_a  = ra;
        id_e.rs_b  = rb;
        id_e.use_a = bus.id_use_a;
        id_e.use_b = bus.id_use_b;
        id_e.halt  = bus.id_halt;
    end

    assign hit_ex_a  = bus.id_use_a & sb_hit(ex_q,  ra);
    assign hit_ex_b  = bus.id_use_b & sb_hit(ex_q,  rb);
    assign hit_mem_a = bus.id_use_a & sb_hit(mem_q, ra);
    assign hit_mem_b = bus.id_use_b & sb_hit(mem_q, rb);
    assign hit_wb_a  = bus.id_use_a & sb_hit(wb_q,  ra);
    assign hit_wb_b  = bus.id_use_b & sb_hit(wb_q,  rb);

    // With forwarding only a late (load/input) producer in EX is unreachable;
    // without it, any in-flight writer blocks the read until it has retired.
    always_comb begin
        if (FWD_EN)
            stall = (hit_ex_a | hit_ex_b) & ex_q.late;
        else
            stall = hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b | hit_wb_a | hit_wb_b;
        stall = stall & bus.id_valid & (state_q == RUN);
    end

    assign flush   = (state_q == RUN) & bus.ex_branch_taken;
    assign advance = (state_q == RUN) & ~stall & ~bus.ex_branch_taken;

    hazard_sb_stage u_ex  (.clk(clk), .rst_n(rst_n), .load_i(advance), .d_i(id_e),  .q_o(ex_q));
    hazard_sb_stage u_mem (.clk(clk), .rst_n(rst_n), .load_i(1'b1),    .d_i(ex_q),  .q_o(mem_q));
    hazard_sb_stage u_wb  (.clk(clk), .rst_n(rst_n), .load_i(1'b1),    .d_i(mem_q), .q_o(wb_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.halted      = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) begin
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                end else if (stall) begin
                    bus.pc_en       = 1'b0;
                    bus.ifid_en     = 1'b0;
                    bus.idex_bubble = 1'b1;
                end
                if (advance & bus.id_valid & bus.id_halt) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            DRAIN: begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_d == '0) state_d = HALTED;
            end
            HALTED: begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
                bus.halted      = 1'b1;
                if (bus.resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // MEM is the younger result, so it wins over WB for the same register.
    always_comb begin
        bus.fwd_a = FWD_REG;
        bus.fwd_b = FWD_REG;
        if (FWD_EN && state_q != HALTED && ex_q.v) begin
            if (ex_q.use_a) begin
                if (sb_hit(mem_q, ex_q.rs_a))     bus.fwd_a = FWD_MEM;
                else if (sb_hit(wb_q, ex_q.rs_a)) bus.fwd_a = FWD_WB;
            end
            if (ex_q.use_b) begin
                if (sb_hit(mem_q, ex_q.rs_b))     bus.fwd_b = FWD_MEM;
                else if (sb_hit(wb_q, ex_q.rs_b)) bus.fwd_b = FWD_WB;
            end
        end
    end

    logic unused_sb;
    assign unused_sb = ^{ex_q.halt, wb_q.late, wb_q.rs_a, wb_q.rs_b,
                         wb_q.use_a, wb_q.use_b, wb_q.halt};

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed checks of hazard_ctl: one instance with forwarding, one without,
// both fed the same decoder stream.
module tb_hazard_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_use_a, id_use_b, id_regwrite, id_late, id_halt;
    logic [2:0] id_rs_a, id_rs_b, id_regdst;
    logic       ex_branch_taken, resume;

    int n_chk = 0;
    int n_pass = 0;

    hazard_ctl_if #(.REG_AW(3)) ifa ();
    hazard_ctl_if #(.REG_AW(3)) ifb ();

    assign ifa.id_valid = id_valid;          assign ifb.id_valid = id_valid;
    assign ifa.id_rs_a = id_rs_a;            assign ifb.id_rs_a = id_rs_a;
    assign ifa.id_rs_b = id_rs_b;            assign ifb.id_rs_b = id_rs_b;
    assign ifa.id_use_a = id_use_a;          assign ifb.id_use_a = id_use_a;
    assign ifa.id_use_b = id_use_b;          assign ifb.id_use_b = id_use_b;
    assign ifa.id_regwrite = id_regwrite;    assign ifb.id_regwrite = id_regwrite;
    assign ifa.id_regdst = id_regdst;        assign ifb.id_regdst = id_regdst;
    assign ifa.id_late = id_late;            assign ifb.id_late = id_late;
    assign ifa.id_halt = id_halt;            assign ifb.id_halt = id_halt;
    assign ifa.ex_branch_taken = ex_branch_taken;
    assign ifb.ex_branch_taken = ex_branch_taken;
    assign ifa.resume = resume;              assign ifb.resume = resume;

    hazard_ctl #(.REG_AW(3), .FWD_EN(1'b1), .DRAIN_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    hazard_ctl #(.REG_AW(3), .FWD_EN(1'b0), .DRAIN_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ins(input logic v, input logic [2:0] ra, input logic ua,
                       input logic [2:0] rb, input logic ub, input logic wr,
                       input logic [2:0] dst, input logic late, input logic halt);
        id_valid = v;  id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
        id_regwrite = wr; id_regdst = dst; id_late = late; id_halt = halt;
    endtask

    task automatic idle();
        ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        ex_branch_taken = 1'b0;
        resume = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    int stalls_a, stalls_b;
    logic [1:0] fwd_or_b;

    initial begin
        idle();
        ex_branch_taken = 1'b0;
        resume = 1'b0;
        #3;
        chk("rst_pc_en", {7'd0, ifa.pc_en}, 8'd1);
        chk("rst_ifid_en", {7'd0, ifa.ifid_en}, 8'd1);
        chk("rst_flush_bubble", {6'd0, ifa.ifid_flush, ifa.idex_bubble}, 8'd0);
        chk("rst_fwd", {4'd0, ifa.fwd_a, ifa.fwd_b}, 8'd0);
        chk("rst_halted", {7'd0, ifa.halted}, 8'd0);
        chk("rst_sb_v", {5'd0, dut_a.ex_q.v, dut_a.mem_q.v, dut_a.wb_q.v}, 8'd0);
        do_reset();

        // load r3 then add reading r3: one load-use stall, then WB forward
        ins(1, 0, 0, 0, 0, 1, 3'd3, 1, 0);
        @(negedge clk); chk("lu_no_stall_first", {7'd0, ifa.pc_en}, 8'd1);
        step();
        ins(1, 3'd3, 1, 0, 0, 1, 3'd4, 0, 0);
        @(negedge clk);
        chk("lu_stall", {5'd0, ifa.pc_en, ifa.ifid_en, ifa.idex_bubble}, 8'b001);
        step();
        @(negedge clk);
        chk("lu_release", {5'd0, ifa.pc_en, ifa.ifid_en, ifa.idex_bubble}, 8'b110);
        step();
        idle();
        @(negedge clk); chk("lu_fwd_wb", {6'd0, ifa.fwd_a}, 8'd2);
        step();

        // add r2 -> sub reading r2 on rs_b, with 0/1/2 spacers
        ins(1, 0, 0, 0, 0, 1, 3'd2, 0, 0);
        step();
        ins(1, 0, 0, 3'd2, 1, 1, 3'd6, 0, 0);
        @(negedge clk); chk("alu_no_stall", {7'd0, ifa.pc_en}, 8'd1);
        step();
        idle();
        @(negedge clk); chk("fwd_b_mem", {6'd0, ifa.fwd_b}, 8'd1);
        step();
        ins(1, 0, 0, 0, 0, 1, 3'd2, 0, 0);
        step();
        idle();
        step();
        ins(1, 0, 0, 3'd2, 1, 1, 3'd6, 0, 0);
        step();
        idle();
        @(negedge clk); chk("fwd_b_wb", {6'd0, ifa.fwd_b}, 8'd2);
        step();
        ins(1, 0, 0, 0, 0, 1, 3'd2, 0, 0);
        step();
        idle(); step(); step();
        ins(1, 0, 0, 3'd2, 1, 1, 3'd6, 0, 0);
        step();
        idle();
        @(negedge clk); chk("fwd_b_reg", {6'd0, ifa.fwd_b}, 8'd0);
        step();

        // branch taken while load-use stall is pending: flush wins
        do_reset();
        ins(1, 0, 0, 0, 0, 1, 3'd3, 1, 0);
        step();
        ins(1, 3'd3, 1, 0, 0, 1, 3'd4, 0, 0);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("flush_ctl", {4'd0, ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_bubble}, 8'b1111);
        step();
        ex_branch_taken = 1'b0;
        idle();
        @(negedge clk);
        chk("post_flush", {5'd0, ifa.pc_en, ifa.ifid_flush, ifa.idex_bubble}, 8'b100);
        step();

        // halt blocked by stall, accepted next cycle, drains, resumes
        do_reset();
        ins(1, 0, 0, 0, 0, 1, 3'd3, 1, 0);
        step();
        ins(1, 3'd3, 1, 0, 0, 0, 3'd0, 0, 1);
        @(negedge clk); chk("halt_stalled", {7'd0, ifa.pc_en}, 8'd0);
        step();
        @(negedge clk); chk("halt_accept_T", {6'd0, ifa.pc_en, ifa.halted}, 8'b10);
        step();
        idle();
        resume = 1'b1;
        @(negedge clk); chk("drain_T1", {6'd0, ifa.pc_en, ifa.halted}, 8'b00);
        step();
        resume = 1'b0;
        @(negedge clk); chk("drain_T2", {6'd0, ifa.idex_bubble, ifa.halted}, 8'b10);
        step();
        @(negedge clk); chk("halted_T3", {5'd0, ifa.halted, ifa.pc_en, ifa.ifid_en}, 8'b100);
        chk("halted_fwd", {4'd0, ifa.fwd_a, ifa.fwd_b}, 8'd0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        @(negedge clk); chk("resumed", {6'd0, ifa.pc_en, ifa.halted}, 8'b10);
        chk("resumed_sb_v", {5'd0, dut_a.ex_q.v, dut_a.mem_q.v, dut_a.wb_q.v}, 8'd0);
        step();

        // write r5 then read r5 back-to-back: 3 stalls without forwarding, none with
        do_reset();
        ins(1, 0, 0, 0, 0, 1, 3'd5, 0, 0);
        step();
        ins(1, 3'd5, 1, 0, 0, 0, 3'd0, 0, 0);
        stalls_a = 0; stalls_b = 0; fwd_or_b = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!ifa.pc_en) stalls_a++;
            if (!ifb.pc_en) stalls_b++;
            fwd_or_b = fwd_or_b | ifb.fwd_a | ifb.fwd_b;
            step();
        end
        chk("nofwd_stalls", 8'(stalls_b), 8'd3);
        chk("nofwd_fwd_zero", {6'd0, fwd_or_b}, 8'd0);
        chk("fwd_no_stalls", 8'(stalls_a), 8'd0);

        // reset asserted mid-drain
        do_reset();
        ins(1, 0, 0, 0, 0, 0, 3'd0, 0, 1);
        step();
        idle();
        step();
        @(negedge clk); chk("pre_rst_drain", {7'd0, ifa.pc_en}, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_drain_ctl", {6'd0, ifa.pc_en, ifa.halted}, 8'b10);
        chk("rst_drain_sb_v", {5'd0, dut_a.ex_q.v, dut_a.mem_q.v, dut_a.wb_q.v}, 8'd0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        @(negedge clk); chk("post_rst_run", {6'd0, ifa.pc_en, ifa.halted}, 8'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB), sitting beside the per-instruction control decoder.
- Consumes the decoder's ID-stage fields and the EX-stage branch outcome.
- Keeps a shadow scoreboard of in-flight destinations.
- Drives PC and pipe-register enables, bubble insertion, flushes, operand forwarding selects and the halt drain sequence.

Parameters:
REG_AW, 3, register-address width (8 GPRs, no hard-wired zero)
FWD_EN, 1, 1 = forward from MEM/WB; 0 = stall on every RAW hazard instead
DRAIN_CYCLES, 3, cycles from halt entering EX until halted asserts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_a  in  REG_AW  first source register
id_rs_b  in  REG_AW  second source register
id_use_a  in  1  instruction reads rs_a
id_use_b  in  1  instruction reads rs_b
id_regwrite  in  1  decoder RegWrite
id_regdst  in  REG_AW  decoder RegDst
id_late  in  1  result available only after MEM (load or Input; decoder MemtoReg)
id_halt  in  1  decoder Halt
ex_branch_taken  in  1  branch resolved taken in EX this cycle
resume  in  1  single-cycle restart pulse, honoured only in HALTED
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX instead of ID contents
fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB result
fwd_b  out  2  EX operand B source, same encoding
halted  out  1  core stopped

Behaviour:
- Reset (async, rst_n=0):
  - All scoreboard valid bits = 0; FSM = RUN.
  - Outputs: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, halted=0.
- Scoreboard:
  - Registered entries EX, MEM, WB. Each entry holds {v, wr, dst, late, rs_a, rs_b, use_a, use_b, halt}.
  - Every cycle: WB<=MEM, MEM<=EX.
  - EX<=ID fields with v=id_valid when the instruction advances; otherwise EX<=all-zero (bubble).
- RAW hit(stage, r): stage.v & stage.wr & stage.dst==r. Evaluated for each used ID source.
- Stall, combinational:
  - FWD_EN=1: stall = hit(EX) on a used source with EX.late=1 (load-use, exactly 1 cycle).
  - FWD_EN=0: stall = hit on a used source in EX, MEM or WB (regfile writes first half, reads second half; WB hit still stalls for safety).
  - On stall: pc_en=0, ifid_en=0, idex_bubble=1.
- Flush: ex_branch_taken=1 in RUN gives ifid_flush=1 and idex_bubble=1, with pc_en=1 and ifid_en=1. Flush overrides stall in the same cycle.
- Forwarding, combinational from the EX entry's sources:
  - MEM hit has priority over WB hit.
  - Output 00 when !use or FWD_EN=0.
  - A MEM hit with MEM.late=1 never occurs, because the stall guarantees it.
- Advance condition: RUN & !stall & !ex_branch_taken.
- FSM RUN / DRAIN / HALTED:
  - RUN->DRAIN: id_valid & id_halt & advance. The halt enters EX; counter loads DRAIN_CYCLES-1.
  - DRAIN:
    - pc_en=0, ifid_en=0, idex_bubble=1.
    - ex_branch_taken is ignored (nothing older than the halt remains in EX).
    - Counter decrements each cycle; at 0 go to HALTED.
  - HALTED: halted=1, pc_en=0, ifid_en=0, idex_bubble=1, fwd=00.
  - HALTED->RUN: on resume=1. Next cycle pc_en=1 and the scoreboard is empty.
  - resume outside HALTED is ignored.
- A halt in ID while stalled or flushed is not accepted; a flushed halt is discarded.
- Reset mid-DRAIN returns to RUN with an empty scoreboard.
- Control outputs are combinational from FSM state and scoreboard. No extra latency beyond the scoreboard registers.

Decomposition:
- Shared package (pipe_pkg) holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - FSM state enum {RUN, DRAIN, HALTED}
  - Scoreboard entry struct
  - REG_AW default
- One sub-module, hazard_sb_stage: a single scoreboard entry register with load/bubble select, instantiated for EX/MEM/WB.

Test Plan:
- Load r3 (id_late=1, dst 3), then add reading r3 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1. Next cycle fwd_a=10 (WB).
- add r2<-, then sub reading r2 as rs_b (no late) -> no stall, fwd_b=01. One spacer later -> fwd_b=10. Two spacers -> 00.
- ex_branch_taken=1 while load-use stall condition is also true -> ifid_flush=1, idex_bubble=1, pc_en=1. No stall cycle follows.
- Halt accepted in cycle T -> pc_en=0 from T+1; halted=1 at T+3 (DRAIN_CYCLES=3). resume pulse -> pc_en=1, halted=0 next cycle.
- FWD_EN=0: write r5, then read r5 back-to-back -> 3 stall cycles; fwd outputs stay 00.
- Assert rst_n=0 during DRAIN -> immediately halted=0, pc_en=1, all scoreboard valid bits 0.
